led_pwm_peripheral: RTL and testbench

LED_PWM_PERIPHERAL -- requirements
Module: led_pwm_peripheral

---
 rtl/led_pwm_peripheral.sv | 137 +++++++++++++
 tb/tb_led_pwm_peripheral.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/led_pwm_peripheral.sv
// Purpose: memory-mapped LED driver with per-channel static/blink mode, global PWM dimming and SET/CLR/TGL helpers.
// Latency: reads are combinational; a register write at edge N reaches leds_o after edge N+1.
// Backpressure: none; every read and write strobe is accepted in the cycle it is presented.
module led_pwm_peripheral #(
  parameter int NUM_LEDS = 8,
  parameter int PWM_BITS = 8,
  parameter int BLINK_W  = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rd_en_i,
  input  logic                wr_en_i,
  input  logic [31:0]         addr_i,
  input  logic [31:0]         data_i,
  output logic [31:0]         data_o,
  output logic [NUM_LEDS-1:0] leds_o
);

  // Word offsets, i.e. addr_i[4:2] of each register.
  localparam logic [2:0] REG_LED    = 3'd0;
  localparam logic [2:0] REG_OUT    = 3'd1;
  localparam logic [2:0] REG_MODE   = 3'd2;
  localparam logic [2:0] REG_PERIOD = 3'd3;
  localparam logic [2:0] REG_DUTY   = 3'd4;
  localparam logic [2:0] REG_SET    = 3'd5;
  localparam logic [2:0] REG_CLR    = 3'd6;
  localparam logic [2:0] REG_TGL    = 3'd7;

  logic [NUM_LEDS-1:0] led_q, led_d;
  logic [NUM_LEDS-1:0] mode_q, mode_d;
  logic [BLINK_W-1:0]  period_q, period_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [BLINK_W-1:0]  blink_cnt_q, blink_cnt_d;
  logic                blink_ph_q, blink_ph_d;
  logic [NUM_LEDS-1:0] leds_q, leds_d;

  logic [2:0]          word_sel;
  logic                aligned;
  logic                wr_hit;
  logic                period_wr;
  logic                pwm_on;
  logic                unused_bits;

  assign word_sel  = addr_i[4:2];
  assign aligned   = (addr_i[1:0] == 2'b00);
  assign wr_hit    = wr_en_i && aligned;
  assign period_wr = wr_hit && (word_sel == REG_PERIOD);

  // Upper address bits and upper data bits are deliberately ignored.
  assign unused_bits = ^{addr_i[31:5], data_i};

  // Register-file next state: plain writes plus bit-set/clear/toggle on LED.
  always_comb begin
    led_d    = led_q;
    mode_d   = mode_q;
    period_d = period_q;
    duty_d   = duty_q;
    if (wr_hit) begin
      case (word_sel)
        REG_LED:    led_d    = data_i[NUM_LEDS-1:0];
        REG_MODE:   mode_d   = data_i[NUM_LEDS-1:0];
        REG_PERIOD: period_d = data_i[BLINK_W-1:0];
        REG_DUTY:   duty_d   = data_i[PWM_BITS-1:0];
        REG_SET:    led_d    = led_q | data_i[NUM_LEDS-1:0];
        REG_CLR:    led_d    = led_q & ~data_i[NUM_LEDS-1:0];
        REG_TGL:    led_d    = led_q ^ data_i[NUM_LEDS-1:0];
        default:    led_d    = led_q;
      endcase
    end
  end

  // Blink timebase: phase flips every PERIOD+1 cycles; a PERIOD write restarts the high phase.
  always_comb begin
    blink_cnt_d = blink_cnt_q + BLINK_W'(1);
    blink_ph_d  = blink_ph_q;
    if (period_wr || (period_q == '0)) begin
      blink_cnt_d = '0;
      blink_ph_d  = 1'b1;
    end else if (blink_cnt_q == period_q) begin
      blink_cnt_d = '0;
      blink_ph_d  = ~blink_ph_q;
    end
  end

  // PWM compare; an all-ones duty means fully on rather than one dark cycle per period.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
    pwm_on    = (pwm_cnt_q < duty_q) || (duty_q == {PWM_BITS{1'b1}});
  end

  // Per-channel output gating from the current (pre-write) register values.
  always_comb begin
    leds_d = led_q & {NUM_LEDS{pwm_on}} & (~mode_q | {NUM_LEDS{blink_ph_q}});
  end

  // State registers with synchronous reset taking precedence over writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_q       <= '0;
      mode_q      <= '0;
      period_q    <= '0;
      duty_q      <= {PWM_BITS{1'b1}};
      pwm_cnt_q   <= '0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b1;
      leds_q      <= '0;
    end else begin
      led_q       <= led_d;
      mode_q      <= mode_d;
      period_q    <= period_d;
      duty_q      <= duty_d;
      pwm_cnt_q   <= pwm_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      leds_q      <= leds_d;
    end
  end

  assign leds_o = leds_q;

  // Read mux: zero-extended register contents, zero for write-only, unmapped or idle.
  always_comb begin
    data_o = '0;
    if (rd_en_i && aligned) begin
      case (word_sel)
        REG_LED:    data_o[NUM_LEDS-1:0] = led_q;
        REG_OUT:    data_o[NUM_LEDS-1:0] = leds_q;
        REG_MODE:   data_o[NUM_LEDS-1:0] = mode_q;
        REG_PERIOD: data_o[BLINK_W-1:0]  = period_q;
        REG_DUTY:   data_o[PWM_BITS-1:0] = duty_q;
        default:    data_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_led_pwm_peripheral.sv
module tb_led_pwm_peripheral;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_en_i = 1'b0;
  logic        wr_en_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [31:0] data_i = '0;
  logic [31:0] data_o;
  logic [7:0]  leds_o;

  int checks = 0;
  int errors = 0;

  // Reference model: register contents plus elapsed-cycle bookkeeping.
  logic [7:0]  m_led = '0, m_mode = '0, m_duty = 8'hFF, m_out = '0;
  logic [23:0] m_period = '0;
  int          k = 0;   // edges since last reset edge
  int          w = 0;   // value of k right after the last PERIOD write
  logic [31:0] last_rd = '0;

  always #5 clk = ~clk;

  led_pwm_peripheral #(.NUM_LEDS(8), .PWM_BITS(8), .BLINK_W(24)) dut (
    .clk     (clk),
    .rst     (rst),
    .rd_en_i (rd_en_i),
    .wr_en_i (wr_en_i),
    .addr_i  (addr_i),
    .data_i  (data_i),
    .data_o  (data_o),
    .leds_o  (leds_o)
  );

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (a[1:0] != 2'b00) return 32'h0;
    case (a[4:2])
      3'd0:    return {24'h0, m_led};
      3'd1:    return {24'h0, m_out};
      3'd2:    return {24'h0, m_mode};
      3'd3:    return {8'h0, m_period};
      3'd4:    return {24'h0, m_duty};
      default: return 32'h0;
    endcase
  endfunction

  // Blink phase from elapsed time: high for the first PERIOD+1 cycles, then alternating.
  function automatic logic model_ph();
    if (m_period == 24'h0) return 1'b1;
    return (((k - w) / (int'(m_period) + 1)) % 2) == 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input bit r, input bit we, input bit re,
                     input logic [31:0] a, input logic [31:0] d);
    logic [7:0] exp;
    int         pwm;
    bit         on;
    rst = r; wr_en_i = we; rd_en_i = re; addr_i = a; data_i = d;
    #1;
    last_rd = data_o;
    chk("data_o", data_o, re ? model_read(a) : 32'h0);
    if (r) begin
      exp = 8'h00;
      m_led = '0; m_mode = '0; m_period = '0; m_duty = 8'hFF;
      k = 0; w = 0;
    end else begin
      pwm = k % 256;
      on  = (pwm < int'(m_duty)) || (m_duty == 8'hFF);
      exp = on ? (m_led & (~m_mode | (model_ph() ? 8'hFF : 8'h00))) : 8'h00;
      k++;
      if (we && a[1:0] == 2'b00) begin
        case (a[4:2])
          3'd0: m_led  = d[7:0];
          3'd2: m_mode = d[7:0];
          3'd3: begin m_period = d[23:0]; w = k; end
          3'd4: m_duty = d[7:0];
          3'd5: m_led  = m_led | d[7:0];
          3'd6: m_led  = m_led & ~d[7:0];
          3'd7: m_led  = m_led ^ d[7:0];
          default: ;
        endcase
      end
    end
    m_out = exp;
    @(posedge clk);
    #1;
    chk("leds_o", {24'h0, leds_o}, {24'h0, exp});
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cyc(1'b0, 1'b1, 1'b0, a, d);
  endtask

  task automatic rd(input logic [31:0] a);
    cyc(1'b0, 1'b0, 1'b1, a, 32'h0);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    int cnt_a;
    int cnt_b;
    logic [31:0] ra;
    logic [31:0] rdat;

    // Reset defaults
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    rd(32'h00); chk("rst_led", last_rd, 32'h0);
    rd(32'h08); chk("rst_mode", last_rd, 32'h0);
    rd(32'h0C); chk("rst_period", last_rd, 32'h0);
    rd(32'h10); chk("rst_duty", last_rd, 32'hFF);
    chk("rst_leds", {24'h0, leds_o}, 32'h0);

    // Static write with ignored upper bits
    wr(32'h00, 32'hFFFF_FFA5);
    rd(32'h00); chk("static_led", last_rd, 32'h0000_00A5);
    chk("static_leds", {24'h0, leds_o}, 32'hA5);
    rd(32'h04); chk("static_out", last_rd, 32'hA5);

    // Set / clear / toggle, and write-only registers read as zero
    wr(32'h14, 32'h0F); rd(32'h00); chk("set_led", last_rd, 32'hAF);
    rd(32'h14); chk("set_rd0", last_rd, 32'h0);
    wr(32'h18, 32'h03); rd(32'h00); chk("clr_led", last_rd, 32'hAC);
    rd(32'h18); chk("clr_rd0", last_rd, 32'h0);
    wr(32'h1C, 32'hFF); rd(32'h00); chk("tgl_led", last_rd, 32'h53);
    rd(32'h1C); chk("tgl_rd0", last_rd, 32'h0);

    // Misaligned and OUT writes are ignored
    wr(32'h01, 32'h00); wr(32'h04, 32'h00);
    rd(32'h00); chk("ignored_wr", last_rd, 32'h53);

    // Blink: 4-cycle phases on channel 0, channel 1 static
    wr(32'h00, 32'h03); wr(32'h08, 32'h01); wr(32'h0C, 32'h3);
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 32; i++) begin
      idle();
      cnt_a += int'(leds_o[0]);
      cnt_b += int'(!leds_o[1]);
      if (i < 4) chk("blink_first_hi", {31'h0, leds_o[0]}, 32'h1);
    end
    chk("blink_hi_cnt", cnt_a, 32'd16);
    chk("blink_ch1_low", cnt_b, 32'd0);
    for (int i = 0; i < 5; i++) idle();
    chk("blink_midlow", {31'h0, leds_o[0]}, 32'h0);
    wr(32'h0C, 32'h3);
    cnt_a = 0;
    for (int i = 0; i < 4; i++) begin idle(); cnt_a += int'(leds_o[0]); end
    chk("blink_restart_hi", cnt_a, 32'd4);
    cnt_a = 0;
    for (int i = 0; i < 4; i++) begin idle(); cnt_a += int'(leds_o[0]); end
    chk("blink_restart_lo", cnt_a, 32'd0);

    // PWM dimming
    wr(32'h08, 32'h00); wr(32'h00, 32'hFF); wr(32'h10, 32'h40);
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 512; i++) begin
      idle();
      if (leds_o == 8'hFF) cnt_a++;
      if (leds_o == 8'h00) cnt_b++;
    end
    chk("pwm_on_cnt", cnt_a, 32'd128);
    chk("pwm_off_cnt", cnt_b, 32'd384);
    wr(32'h10, 32'h00);
    cnt_a = 0;
    for (int i = 0; i < 256; i++) begin idle(); if (leds_o != 8'h00) cnt_a++; end
    chk("pwm_duty0", cnt_a, 32'd0);
    wr(32'h10, 32'hFF);
    cnt_a = 0;
    for (int i = 0; i < 256; i++) begin idle(); if (leds_o != 8'hFF) cnt_a++; end
    chk("pwm_dutyff", cnt_a, 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      ra = {27'h0, 3'($urandom_range(0, 7)), 2'b00};
      if ($urandom_range(0, 7) == 0) ra = $urandom;
      rdat = $urandom;
      if (ra[4:0] == 5'h0C) rdat = {8'($urandom), 24'($urandom_range(0, 6))};
      cyc(($urandom_range(0, 49) == 0), 1'($urandom), 1'($urandom), ra, rdat);
    end

    // Reset wins over a simultaneous write while blinking
    wr(32'h10, 32'hFF); wr(32'h00, 32'hFF); wr(32'h08, 32'hFF); wr(32'h0C, 32'h2);
    for (int i = 0; i < 4; i++) idle();
    cyc(1'b1, 1'b1, 1'b0, 32'h00, 32'hFF);
    chk("rstwr_leds", {24'h0, leds_o}, 32'h0);
    rd(32'h00); chk("rstwr_led", last_rd, 32'h0);
    rd(32'h0C); chk("rstwr_period", last_rd, 32'h0);
    wr(32'h08, 32'h01); wr(32'h00, 32'h01); idle();
    chk("rstwr_ph_hi", {31'h0, leds_o[0]}, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
